// File: rtl/pmem_line_adaptor.sv
// Cache line port to narrow burst-memory adaptor: one line = BEATS bursts of BURST_W.
// Optional PMEM_ADAPTOR_PERF_EN adds completed read/write line counters.
module pmem_line_adaptor #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic                read_i,
    input  logic                write_i,
    input  logic [LINE_W-1:0]   line_i,
    output logic [LINE_W-1:0]   line_o,
    output logic                resp_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic [BURST_W-1:0]  burst_i,
    output logic [BURST_W-1:0]  burst_o,
    input  logic                resp_i
`ifdef PMEM_ADAPTOR_PERF_EN
    ,
    output logic [31:0]         rd_count_o,
    output logic [31:0]         wr_count_o
`endif
);

    localparam int unsigned BEATS = LINE_W / BURST_W;
    localparam int unsigned OFFS  = $clog2(LINE_W / 8);
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W - OFFS){1'b1}}, {OFFS{1'b0}}};

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t                           state, state_next;
    logic [CNT_W-1:0]                 beat, beat_inc;
    logic                             last_beat;
    logic [BEATS-1:0][BURST_W-1:0]    wbuf;
    logic [BEATS-1:0][BURST_W-1:0]    line_q;

    assign last_beat = (beat == CNT_W'(BEATS - 1));
    assign beat_inc  = last_beat ? '0 : beat + 1'b1;
    assign line_o    = line_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (write_i)     state_next = WR;
                else if (read_i) state_next = RD;
            end
            RD:      if (resp_i && last_beat) state_next = DONE;
            WR:      if (resp_i && last_beat) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are registered copies of the next state, so they align with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
            beat      <= '0;
            address_o <= '0;
            burst_o   <= '0;
            wbuf      <= '0;
            line_q    <= '0;
        end else begin
            read_o  <= (state_next == RD);
            write_o <= (state_next == WR);
            resp_o  <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (write_i || read_i) begin
                        address_o <= address_i & ALIGN_MASK;
                        beat      <= '0;
                    end
                    if (write_i) begin
                        wbuf    <= line_i;
                        burst_o <= line_i[BURST_W-1:0];
                    end
                end
                RD: begin
                    if (resp_i) begin
                        line_q[beat] <= burst_i;
                        beat         <= beat_inc;
                    end
                end
                WR: begin
                    if (resp_i) begin
                        beat    <= beat_inc;
                        burst_o <= wbuf[beat_inc];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PMEM_ADAPTOR_PERF_EN
    logic op_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr      <= 1'b0;
            rd_count_o <= '0;
            wr_count_o <= '0;
        end else begin
            if (state == IDLE && (write_i || read_i)) op_wr <= write_i;
            if (state == DONE) begin
                if (op_wr) wr_count_o <= wr_count_o + 32'd1;
                else       rd_count_o <= rd_count_o + 32'd1;
            end
        end
    end
`endif

endmodule
